// File: rtl/bsg_fsb_out_rr_arbiter.sv
// Round-robin arbiter sharing one FSB output channel among num_req_p sources.
// A grant is held for up to max_burst_p words; one idle cycle separates grants.
module bsg_fsb_out_rr_arbiter #(
    parameter int ring_width_p = 80,
    parameter int num_req_p    = 4,
    parameter int max_burst_p  = 4,
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              en_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*ring_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    output logic                              v_o,
    output logic [ring_width_p-1:0]           data_o,
    input  logic                              yumi_i,
    output logic                              grant_v_o,
    output logic [id_width_lp-1:0]            grant_id_o,
    output logic [15:0]                       sent_count_o
);

    localparam int burst_width_lp = (max_burst_p > 1) ? $clog2(max_burst_p) : 1;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                    r_state;
    logic [id_width_lp-1:0]    r_ptr;
    logic [id_width_lp-1:0]    r_grant_id;
    logic [burst_width_lp-1:0] r_burst;
    logic [15:0]               r_sent;

    logic [ring_width_p-1:0]   w_words [num_req_p];
    logic [id_width_lp:0]      w_sum;
    logic [id_width_lp-1:0]    w_scan_id;
    logic [id_width_lp-1:0]    w_pick;
    logic [id_width_lp-1:0]    w_next_ptr;
    logic                      w_found;
    logic                      w_granted;
    logic                      w_cur_v;
    logic                      w_fire;
    logic                      w_last;
    logic                      w_release;

    for (genvar k = 0; k < num_req_p; k++) begin : g_words
        assign w_words[k] = req_data_i[k*ring_width_p +: ring_width_p];
    end

    // Scan requesters starting at the rr pointer, wrapping modulo num_req_p.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = '0;
        w_sum     = '0;
        w_scan_id = '0;
        for (int i = 0; i < num_req_p; i++) begin
            w_sum = {1'b0, r_ptr} + (id_width_lp+1)'(i);
            if (w_sum >= (id_width_lp+1)'(num_req_p))
                w_sum = w_sum - (id_width_lp+1)'(num_req_p);
            w_scan_id = w_sum[id_width_lp-1:0];
            if (!w_found && req_v_i[w_scan_id]) begin
                w_found = 1'b1;
                w_pick  = w_scan_id;
            end
        end
    end

    assign w_granted  = (r_state == GRANT);
    assign w_cur_v    = w_granted & req_v_i[r_grant_id];
    assign w_fire     = w_cur_v & yumi_i;
    assign w_last     = (r_burst == burst_width_lp'(max_burst_p - 1));
    assign w_release  = (w_fire & w_last) | ~req_v_i[r_grant_id] | (~en_i & w_fire);
    assign w_next_ptr = (r_grant_id == id_width_lp'(num_req_p - 1)) ? '0
                                                                     : r_grant_id + id_width_lp'(1);

    assign v_o          = w_cur_v;
    assign data_o       = w_granted ? w_words[r_grant_id] : '0;
    assign grant_v_o    = w_granted;
    assign grant_id_o   = r_grant_id;
    assign sent_count_o = r_sent;

    // Only the granted requester sees yumi, and only while its word is offered.
    always_comb begin
        req_yumi_o = '0;
        if (w_fire)
            req_yumi_o[r_grant_id] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_burst    <= '0;
            r_sent     <= '0;
        end else begin
            if (w_fire && (r_sent != 16'hFFFF))
                r_sent <= r_sent + 16'd1;
            case (r_state)
                IDLE: begin
                    if (en_i && w_found) begin
                        r_grant_id <= w_pick;
                        r_burst    <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_fire)
                        r_burst <= r_burst + burst_width_lp'(1);
                    if (w_release) begin
                        r_state <= IDLE;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_fsb_out_rr_arbiter.sv
// Scoreboard bench for bsg_fsb_out_rr_arbiter: instance A uses max_burst_p=4,
// instance B uses max_burst_p=1; both share the requester-side stimulus.
module tb_bsg_fsb_out_rr_arbiter;

    localparam int W  = 80;
    localparam int N  = 4;
    localparam int ID = 2;

    typedef struct packed {
        logic [ID-1:0] id;
        logic [W-1:0]  data;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           en;
    logic [N-1:0]   req_v;
    logic [N*W-1:0] req_data;
    logic           yumi;

    logic [N-1:0]   a_req_yumi, b_req_yumi;
    logic           a_v, b_v, a_gv, b_gv;
    logic [W-1:0]   a_data, b_data;
    logic [ID-1:0]  a_gid, b_gid;
    logic [15:0]    a_cnt, b_cnt;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] src [N][$];
    exp_t         sb [$];
    logic [N-1:0] vMask;
    logic         yumiEn;
    logic         useB;

    always #5 clk = ~clk;

    bsg_fsb_out_rr_arbiter #(.ring_width_p(W), .num_req_p(N), .max_burst_p(4)) dutA (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .req_v_i(req_v), .req_data_i(req_data),
        .req_yumi_o(a_req_yumi), .v_o(a_v), .data_o(a_data), .yumi_i(yumi),
        .grant_v_o(a_gv), .grant_id_o(a_gid), .sent_count_o(a_cnt)
    );

    bsg_fsb_out_rr_arbiter #(.ring_width_p(W), .num_req_p(N), .max_burst_p(1)) dutB (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .req_v_i(req_v), .req_data_i(req_data),
        .req_yumi_o(b_req_yumi), .v_o(b_v), .data_o(b_data), .yumi_i(yumi),
        .grant_v_o(b_gv), .grant_id_o(b_gid), .sent_count_o(b_cnt)
    );

    function automatic logic [W-1:0] mkword(int tag);
        logic [W-1:0] w;
        w = {tag[15:0], $urandom(), $urandom()};
        return w;
    endfunction

    // Present each requester's head word, then answer with a late yumi.
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_v[k]            = vMask[k] && (src[k].size() > 0);
            req_data[k*W +: W]  = (src[k].size() > 0) ? src[k][0] : '0;
        end
        #1;
        yumi = yumiEn && (useB ? b_v : a_v);
        #1;
    endtask

    task automatic step();
        logic [N-1:0] y;
        y = useB ? b_req_yumi : a_req_yumi;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++)
            if (y[k]) void'(src[k].pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) src[k].delete();
        sb.delete();
        vMask = '0; yumiEn = 1'b0; en = 1'b1; useB = 1'b0;
        reset_n = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b1; useB = 1'b0; vMask = '1; yumiEn = 1'b1;
        for (int k = 0; k < N; k++) src[k].push_back(mkword(k));
        drive();
        @(posedge clk);
        #1;
        checks++; if (a_v !== 1'b0) begin failures++; $display("[TB] FAIL reset_v got=%b exp=0", a_v); end
        checks++; if (a_gv !== 1'b0) begin failures++; $display("[TB] FAIL reset_grant_v got=%b exp=0", a_gv); end
        checks++; if (a_req_yumi !== 4'b0000) begin failures++; $display("[TB] FAIL reset_req_yumi got=%b exp=0000", a_req_yumi); end
        checks++; if (a_gid !== 2'd0) begin failures++; $display("[TB] FAIL reset_grant_id got=%0d exp=0", a_gid); end
        checks++; if (a_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_sent_count got=%0d exp=0", a_cnt); end
        checks++; if (a_data !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", a_data); end
        checks++; if (b_gv !== 1'b0) begin failures++; $display("[TB] FAIL reset_grant_v_b got=%b exp=0", b_gv); end
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        logic [8:0] expV;
        exp_t e;
        do_reset();
        expV = 9'b011011110;
        for (int i = 0; i < 6; i++) begin
            e.id = 2'd0; e.data = mkword(16'h100 + i);
            src[0].push_back(e.data);
            sb.push_back(e);
        end
        vMask = 4'b0001; yumiEn = 1'b1;
        for (int c = 0; c < 9; c++) begin
            drive();
            checks++; if (a_v !== expV[c]) begin failures++; $display("[TB] FAIL burst_v cyc=%0d got=%b exp=%b", c, a_v, expV[c]); end
            if (a_v && yumi) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("[TB] FAIL burst_extra_word got=%h exp=none", a_data); end
                else begin
                    e = sb.pop_front();
                    if (a_data !== e.data || a_gid !== e.id) begin
                        failures++; $display("[TB] FAIL burst_word got=%0d:%h exp=%0d:%h", a_gid, a_data, e.id, e.data);
                    end
                end
            end
            step();
        end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL burst_left got=%0d exp=0", sb.size()); end
        checks++; if (a_cnt !== 16'd6) begin failures++; $display("[TB] FAIL burst_sent_count got=%0d exp=6", a_cnt); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [N-1:0] m;
        int c;
        do_reset();
        useB = 1'b1;
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < N; k++) begin
                e.id = ID'(k); e.data = mkword(16'h200 + j*N + k);
                src[k].push_back(e.data);
                sb.push_back(e);
            end
        vMask = '1; yumiEn = 1'b1;
        c = 0;
        while (sb.size() > 0 && c < 40) begin
            drive();
            if (b_v && yumi) begin
                e = sb.pop_front();
                m = '0; m[e.id] = 1'b1;
                checks++; if (b_gid !== e.id) begin failures++; $display("[TB] FAIL rr_grant_id got=%0d exp=%0d", b_gid, e.id); end
                checks++; if (b_data !== e.data) begin failures++; $display("[TB] FAIL rr_data got=%h exp=%h", b_data, e.data); end
                checks++; if (b_req_yumi !== m) begin failures++; $display("[TB] FAIL rr_req_yumi got=%b exp=%b", b_req_yumi, m); end
                checks++; if (b_gv !== 1'b1) begin failures++; $display("[TB] FAIL rr_grant_v got=%b exp=1", b_gv); end
            end else begin
                checks++; if (b_req_yumi !== 4'b0000) begin failures++; $display("[TB] FAIL rr_req_yumi_idle got=%b exp=0000", b_req_yumi); end
            end
            step();
            c++;
        end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL rr_timeout got=%0d exp=0", sb.size()); end
        drive();
        checks++; if (b_cnt !== 16'd8) begin failures++; $display("[TB] FAIL rr_sent_count got=%0d exp=8", b_cnt); end
        useB = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [6:0] expV;
        exp_t e;
        do_reset();
        expV = 7'b0101111;
        for (int i = 0; i < 5; i++) begin
            e.id = 2'd2; e.data = mkword(16'h300 + i);
            src[2].push_back(e.data);
            sb.push_back(e);
        end
        vMask = 4'b0100; yumiEn = 1'b0;
        drive();
        step();
        for (int c = 0; c < 5; c++) begin
            drive();
            checks++; if (a_v !== 1'b1) begin failures++; $display("[TB] FAIL bp_v cyc=%0d got=%b exp=1", c, a_v); end
            checks++; if (a_data !== sb[0].data) begin failures++; $display("[TB] FAIL bp_data cyc=%0d got=%h exp=%h", c, a_data, sb[0].data); end
            checks++; if (a_req_yumi !== 4'b0000) begin failures++; $display("[TB] FAIL bp_req_yumi cyc=%0d got=%b exp=0000", c, a_req_yumi); end
            checks++; if (a_gid !== 2'd2) begin failures++; $display("[TB] FAIL bp_grant_id cyc=%0d got=%0d exp=2", c, a_gid); end
            step();
        end
        yumiEn = 1'b1;
        for (int c = 0; c < 7; c++) begin
            drive();
            checks++; if (a_v !== expV[c]) begin failures++; $display("[TB] FAIL bp_release_v cyc=%0d got=%b exp=%b", c, a_v, expV[c]); end
            if (a_v && yumi) begin
                checks++; if (a_req_yumi !== 4'b0100) begin failures++; $display("[TB] FAIL bp_req_yumi_on got=%b exp=0100", a_req_yumi); end
                checks++;
                if (sb.size() == 0) begin failures++; $display("[TB] FAIL bp_extra_word got=%h exp=none", a_data); end
                else begin
                    e = sb.pop_front();
                    if (a_data !== e.data) begin failures++; $display("[TB] FAIL bp_word got=%h exp=%h", a_data, e.data); end
                end
            end
            step();
        end
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL bp_left got=%0d exp=0", sb.size()); end
        checks++; if (a_cnt !== 16'd5) begin failures++; $display("[TB] FAIL bp_sent_count got=%0d exp=5", a_cnt); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        src[0].push_back(mkword(16'h400));
        for (int k = 0; k < N; k++) src[k].push_back(mkword(16'h410 + k));
        vMask = '1;
        for (int c = 0; c < 10; c++) begin
            en     = (c == 0) || (c >= 8);
            yumiEn = (c >= 4);
            drive();
            if (c >= 1 && c <= 3) begin
                checks++; if (a_v !== 1'b1 || a_gid !== 2'd0) begin failures++; $display("[TB] FAIL en_hold cyc=%0d got=v%b/id%0d exp=v1/id0", c, a_v, a_gid); end
            end
            if (c == 4) begin
                checks++; if (a_req_yumi !== 4'b0001) begin failures++; $display("[TB] FAIL en_yumi got=%b exp=0001", a_req_yumi); end
            end
            if (c >= 5 && c <= 7) begin
                checks++; if (a_gv !== 1'b0) begin failures++; $display("[TB] FAIL en_no_grant cyc=%0d got=%b exp=0", c, a_gv); end
            end
            if (c == 9) begin
                checks++; if (a_gid !== 2'd1 || a_v !== 1'b1) begin failures++; $display("[TB] FAIL en_regrant got=v%b/id%0d exp=v1/id1", a_v, a_gid); end
            end
            step();
        end
        en = 1'b1;
    endtask

    task automatic test_valid_drop();
        logic [W-1:0] w3;
        do_reset();
        for (int i = 0; i < 4; i++) src[1].push_back(mkword(16'h500 + i));
        w3 = mkword(16'h530);
        vMask = 4'b0010; yumiEn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                vMask = 4'b1001;
                src[3].push_back(w3);
                src[0].push_back(mkword(16'h540));
            end
            drive();
            if (c == 1 || c == 2) begin
                checks++; if (a_v !== 1'b1 || a_gid !== 2'd1) begin failures++; $display("[TB] FAIL vd_burst cyc=%0d got=v%b/id%0d exp=v1/id1", c, a_v, a_gid); end
            end
            if (c == 3) begin
                checks++; if (a_v !== 1'b0) begin failures++; $display("[TB] FAIL vd_drop_v got=%b exp=0", a_v); end
            end
            if (c == 4) begin
                checks++; if (a_gv !== 1'b0 || a_gid !== 2'd1) begin failures++; $display("[TB] FAIL vd_idle got=gv%b/id%0d exp=gv0/id1", a_gv, a_gid); end
            end
            if (c == 5) begin
                checks++; if (a_gid !== 2'd3 || a_v !== 1'b1) begin failures++; $display("[TB] FAIL vd_next_grant got=v%b/id%0d exp=v1/id3", a_v, a_gid); end
                checks++; if (a_data !== w3) begin failures++; $display("[TB] FAIL vd_next_data got=%h exp=%h", a_data, w3); end
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w1;
        do_reset();
        src[2].push_back(mkword(16'h600));
        for (int i = 0; i < 3; i++) src[3].push_back(mkword(16'h610 + i));
        vMask = 4'b1100; yumiEn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive();
            step();
        end
        drive();
        checks++; if (a_v !== 1'b1 || a_gid !== 2'd3) begin failures++; $display("[TB] FAIL ar_pre got=v%b/id%0d exp=v1/id3", a_v, a_gid); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (a_v !== 1'b0) begin failures++; $display("[TB] FAIL ar_v got=%b exp=0", a_v); end
        checks++; if (a_gv !== 1'b0) begin failures++; $display("[TB] FAIL ar_grant_v got=%b exp=0", a_gv); end
        checks++; if (a_req_yumi !== 4'b0000) begin failures++; $display("[TB] FAIL ar_req_yumi got=%b exp=0000", a_req_yumi); end
        checks++; if (a_cnt !== 16'd0) begin failures++; $display("[TB] FAIL ar_sent_count got=%0d exp=0", a_cnt); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        w1 = mkword(16'h620);
        src[1].push_back(w1);
        vMask = 4'b1010;
        drive();
        checks++; if (a_gv !== 1'b0) begin failures++; $display("[TB] FAIL ar_idle got=%b exp=0", a_gv); end
        step();
        drive();
        checks++; if (a_gid !== 2'd1 || a_v !== 1'b1) begin failures++; $display("[TB] FAIL ar_first_grant got=v%b/id%0d exp=v1/id1", a_v, a_gid); end
        checks++; if (a_data !== w1) begin failures++; $display("[TB] FAIL ar_first_data got=%h exp=%h", a_data, w1); end
        step();
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_enable_drop();
        test_valid_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
